// File: rtl/coherence_bus_arbiter_pkg.sv
// Shared types for the L2/L3 coherence arbiter.
//   mesi_state_t : 2-bit MESI encoding used on snoop_state and resp_state
//   arb_state_t  : arbiter FSM states, also visible on dbg_state
package cache_config;
  localparam int MESI_STATE_WIDTH       = 2;
  localparam int ADDRESS_WIDTH          = 32;
  localparam int MAIN_MEMORY_DATA_WIDTH = 32;

  typedef enum logic [MESI_STATE_WIDTH-1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_state_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNOOP = 2'd1,
    WB    = 2'd2,
    RESP  = 2'd3
  } arb_state_t;
endpackage

// File: rtl/coherence_bus_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index of the last winner; search starts at ptr+1 and wraps
//   grant : one-hot winner (all zero when req is empty)
//   index : binary index of the winner (0 when req is empty)
module rr_priority_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant = '0;
    index = '0;
    cand  = '0;
    found = 1'b0;
    // k runs 1..N so the previous winner is considered last.
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Snooping coherence arbiter between NUM_CACHES private L2s and the shared L3.
//   req_valid/req_is_write/req_addr : per-L2 requests, held until resp_valid
//   grant                           : one-hot bus owner, SNOOP entry through RESP
//   snoop_*                         : broadcast to every other L2, ack/state/data back
//   resp_*                          : one-cycle completion with installed MESI state
//   wb_*                            : writeback of Modified data on a read demotion
//   timeout_err                     : pulse on the last SNOOP cycle when acks are missing
//   dbg_state                       : current FSM state
// Handshake: resp_valid and timeout_err are single-cycle pulses with no back-pressure;
// wb_valid holds wb_addr/wb_data stable until the cycle wb_ready is sampled high.
module coherence_bus_arbiter
  import cache_config::*;
#(
  parameter int NUM_CACHES    = 4,
  parameter int ADDR_W        = ADDRESS_WIDTH,
  parameter int DATA_W        = MAIN_MEMORY_DATA_WIDTH,
  parameter int SNOOP_TIMEOUT = 15
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_CACHES-1:0]                  req_valid,
  input  logic [NUM_CACHES-1:0]                  req_is_write,
  input  logic [NUM_CACHES*ADDR_W-1:0]           req_addr,
  output logic [NUM_CACHES-1:0]                  grant,
  output logic                                   snoop_valid,
  output logic [ADDR_W-1:0]                      snoop_addr,
  output logic                                   snoop_invalidate,
  output logic [NUM_CACHES-1:0]                  snoop_target,
  input  logic [NUM_CACHES-1:0]                  snoop_ack,
  input  logic [NUM_CACHES*MESI_STATE_WIDTH-1:0] snoop_state,
  input  logic [NUM_CACHES*DATA_W-1:0]           snoop_data,
  output logic                                   resp_valid,
  output logic [MESI_STATE_WIDTH-1:0]            resp_state,
  output logic                                   resp_data_valid,
  output logic [DATA_W-1:0]                      resp_data,
  output logic                                   wb_valid,
  output logic [ADDR_W-1:0]                      wb_addr,
  output logic [DATA_W-1:0]                      wb_data,
  input  logic                                   wb_ready,
  output logic                                   timeout_err,
  output arb_state_t                             dbg_state
);

  localparam int IW = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1;
  localparam int CW = $clog2(SNOOP_TIMEOUT + 1);
  localparam int SW = MESI_STATE_WIDTH;

  arb_state_t                   state_q, state_d;
  logic [NUM_CACHES-1:0]        grant_q, grant_d;
  logic [IW-1:0]                idx_q, idx_d, rr_q, rr_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic                         wr_q, wr_d;
  logic [NUM_CACHES-1:0]        mask_q, mask_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [NUM_CACHES*SW-1:0]     st_q, st_d;
  logic [NUM_CACHES*DATA_W-1:0] dat_q, dat_d;
  mesi_state_t                  rstate_q, rstate_d;
  logic [DATA_W-1:0]            rdata_q, rdata_d;
  logic                         rdv_q, rdv_d;

  logic [NUM_CACHES-1:0]        pick_grant;
  logic [IW-1:0]                pick_idx;
  logic [NUM_CACHES-1:0]        new_ack;
  logic                         all_acked, last_cycle;
  logic                         m_found, s_found;
  logic [DATA_W-1:0]            m_data, s_data;

  rr_priority_picker #(.N(NUM_CACHES), .IW(IW)) u_picker (
    .req   (req_valid),
    .ptr   (rr_q),
    .grant (pick_grant),
    .index (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    idx_d       = idx_q;
    rr_d        = rr_q;
    addr_d      = addr_q;
    wr_d        = wr_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    st_d        = st_q;
    dat_d       = dat_q;
    rstate_d    = rstate_q;
    rdata_d     = rdata_q;
    rdv_d       = rdv_q;
    new_ack     = '0;
    all_acked   = 1'b0;
    last_cycle  = 1'b0;
    timeout_err = 1'b0;
    m_found     = 1'b0;
    s_found     = 1'b0;
    m_data      = '0;
    s_data      = '0;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = SNOOP;
          grant_d = pick_grant;
          idx_d   = pick_idx;
          addr_d  = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wr_d    = req_is_write[pick_idx];
          mask_d  = '0;
          cnt_d   = '0;
        end
      end
      SNOOP: begin
        // Only first acks from targets are captured; the requester's own lane
        // and repeats are dropped.
        new_ack = snoop_ack & ~grant_q & ~mask_q;
        mask_d  = mask_q | new_ack;
        for (int i = 0; i < NUM_CACHES; i++) begin
          if (new_ack[i]) begin
            st_d[i*SW +: SW]         = snoop_state[i*SW +: SW];
            dat_d[i*DATA_W +: DATA_W] = snoop_data[i*DATA_W +: DATA_W];
          end
        end
        cnt_d      = cnt_q + CW'(1);
        all_acked  = (mask_d == ~grant_q);
        last_cycle = (cnt_q == CW'(SNOOP_TIMEOUT - 1));
        if (all_acked || last_cycle) begin
          timeout_err = !all_acked;
          // Descending scan so the lowest-index holder overwrites last and wins.
          // Unacked lanes are excluded, which treats them as Invalid.
          for (int i = NUM_CACHES - 1; i >= 0; i--) begin
            if (mask_d[i]) begin
              if (st_d[i*SW +: SW] == MESI_M) begin
                m_found = 1'b1;
                m_data  = dat_d[i*DATA_W +: DATA_W];
              end else if (st_d[i*SW +: SW] == MESI_S || st_d[i*SW +: SW] == MESI_E) begin
                s_found = 1'b1;
                s_data  = dat_d[i*DATA_W +: DATA_W];
              end
            end
          end
          rdv_d   = m_found || s_found;
          rdata_d = m_found ? m_data : (s_found ? s_data : '0);
          if (wr_q) begin
            // Dirty ownership moves to the writer, so L3 is not updated.
            rstate_d = MESI_M;
            state_d  = RESP;
          end else if (m_found) begin
            rstate_d = MESI_S;
            state_d  = WB;
          end else begin
            rstate_d = s_found ? MESI_S : MESI_E;
            state_d  = RESP;
          end
        end
      end
      WB: begin
        if (wb_ready) state_d = RESP;
      end
      RESP: begin
        rr_d    = idx_q;
        grant_d = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      rr_q     <= IW'(NUM_CACHES - 1);
      addr_q   <= '0;
      wr_q     <= 1'b0;
      mask_q   <= '0;
      cnt_q    <= '0;
      st_q     <= '0;
      dat_q    <= '0;
      rstate_q <= MESI_I;
      rdata_q  <= '0;
      rdv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      st_q     <= st_d;
      dat_q    <= dat_d;
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rdv_q    <= rdv_d;
    end
  end

  // Outputs are qualified by state so idle cycles show zeros rather than stale data.
  assign grant            = grant_q;
  assign snoop_valid      = (state_q == SNOOP);
  assign snoop_addr       = snoop_valid ? addr_q : '0;
  assign snoop_invalidate = snoop_valid & wr_q;
  assign snoop_target     = snoop_valid ? ~grant_q : '0;
  assign resp_valid       = (state_q == RESP);
  assign resp_state       = resp_valid ? rstate_q : MESI_I;
  assign resp_data_valid  = resp_valid & rdv_q;
  assign resp_data        = resp_valid ? rdata_q : '0;
  // The writeback line is the M holder's data, which is also the response data.
  assign wb_valid         = (state_q == WB);
  assign wb_addr          = wb_valid ? addr_q : '0;
  assign wb_data          = wb_valid ? rdata_q : '0;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
module tb_coherence_bus_arbiter;
  import cache_config::*;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;
  localparam int EW = 2 + 2 + 1 + DW;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_is_write = '0;
  logic [N*AW-1:0]   req_addr = '0;
  logic [N-1:0]      grant;
  logic              snoop_valid;
  logic [AW-1:0]     snoop_addr;
  logic              snoop_invalidate;
  logic [N-1:0]      snoop_target;
  logic [N-1:0]      snoop_ack = '0;
  logic [N*2-1:0]    snoop_state = '0;
  logic [N*DW-1:0]   snoop_data = '0;
  logic              resp_valid;
  logic [1:0]        resp_state;
  logic              resp_data_valid;
  logic [DW-1:0]     resp_data;
  logic              wb_valid;
  logic [AW-1:0]     wb_addr;
  logic [DW-1:0]     wb_data;
  logic              wb_ready = 1'b0;
  logic              timeout_err;
  arb_state_t        dbg_state;

  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_mis = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  coherence_bus_arbiter #(
    .NUM_CACHES(N), .ADDR_W(AW), .DATA_W(DW), .SNOOP_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_is_write(req_is_write), .req_addr(req_addr),
    .grant(grant), .snoop_valid(snoop_valid), .snoop_addr(snoop_addr),
    .snoop_invalidate(snoop_invalidate), .snoop_target(snoop_target),
    .snoop_ack(snoop_ack), .snoop_state(snoop_state), .snoop_data(snoop_data),
    .resp_valid(resp_valid), .resp_state(resp_state),
    .resp_data_valid(resp_data_valid), .resp_data(resp_data),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset        = 1'b0;
    req_valid    = '0;
    req_is_write = '0;
    snoop_ack    = '0;
    snoop_state  = '0;
    snoop_data   = '0;
    wb_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
  endtask

  // One transaction from cache ridx. Targets in ack_mask ack in the first SNOOP
  // cycle with sts/dts; on later SNOOP cycles they keep acking with I and
  // inverted data (must be ignored). The requester lane always acks M and
  // non-acking lanes present M, both of which must be ignored.
  task automatic run_txn(input int ridx, input bit wr, input logic [AW-1:0] addr,
                         input logic [N-1:0] ack_mask, input logic [N*2-1:0] sts,
                         input logic [N*DW-1:0] dts, input int stall,
                         input logic [N-1:0] others);
    logic [N-1:0]    tgt, acks;
    logic [1:0]      e_st;
    logic            e_dv, e_wb, e_to;
    logic [DW-1:0]   e_d;
    int              m, s, exp_snoop, snoop_cyc, wbc, lat, to_cyc;
    bit              done;
    logic [N*2-1:0]  st_v;
    logic [N*DW-1:0] d_v;
    logic [EW-1:0]   ex, got;
    logic [1:0]      gi;

    tgt  = ~(N'(1) << ridx);
    acks = ack_mask & tgt;
    m = -1; s = -1;
    for (int i = 0; i < N; i++) begin
      if (acks[i]) begin
        if (sts[i*2 +: 2] == 2'b11 && m < 0) m = i;
        if ((sts[i*2 +: 2] == 2'b01 || sts[i*2 +: 2] == 2'b10) && s < 0) s = i;
      end
    end
    e_wb = 1'b0;
    if (wr) begin
      e_st = 2'b11;
      e_dv = (m >= 0) || (s >= 0);
      e_d  = (m >= 0) ? dts[m*DW +: DW] : ((s >= 0) ? dts[s*DW +: DW] : '0);
    end else if (m >= 0) begin
      e_st = 2'b01; e_dv = 1'b1; e_d = dts[m*DW +: DW]; e_wb = 1'b1;
    end else if (s >= 0) begin
      e_st = 2'b01; e_dv = 1'b1; e_d = dts[s*DW +: DW];
    end else begin
      e_st = 2'b10; e_dv = 1'b0; e_d = '0;
    end
    e_to      = (acks != tgt);
    exp_snoop = e_to ? TO : 1;
    exp_q.push_back({2'(ridx), e_st, e_dv, e_d});

    req_valid               = (N'(1) << ridx) | others;
    req_is_write[ridx]      = wr;
    req_addr[ridx*AW +: AW] = addr;

    snoop_cyc = 0; wbc = 0; lat = 0; to_cyc = 0; done = 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
      if (snoop_valid) begin
        for (int i = 0; i < N; i++) begin
          if (i == ridx) begin
            st_v[i*2 +: 2] = 2'b11; d_v[i*DW +: DW] = 32'hBAD0_0000 + i;
          end else if (!acks[i]) begin
            st_v[i*2 +: 2] = 2'b11; d_v[i*DW +: DW] = 32'hFFFF_0000 + i;
          end else if (snoop_cyc == 0) begin
            st_v[i*2 +: 2] = sts[i*2 +: 2]; d_v[i*DW +: DW] = dts[i*DW +: DW];
          end else begin
            st_v[i*2 +: 2] = 2'b00; d_v[i*DW +: DW] = ~dts[i*DW +: DW];
          end
        end
        snoop_ack   = acks | (N'(1) << ridx);
        snoop_state = st_v;
        snoop_data  = d_v;
      end else begin
        snoop_ack = '0;
      end
      wb_ready = wb_valid && (wbc >= stall);
      @(negedge clk);
      if (snoop_valid) begin
        if (snoop_cyc == 0) begin
          n_vec++;
          if (grant !== (N'(1) << ridx)) begin
            n_mis++; $display("FAIL grant: got %b want %b", grant, N'(1) << ridx);
          end
          n_vec++;
          if (snoop_target !== tgt) begin
            n_mis++; $display("FAIL snoop_target: got %b want %b", snoop_target, tgt);
          end
          n_vec++;
          if (snoop_addr !== addr) begin
            n_mis++; $display("FAIL snoop_addr: got %h want %h", snoop_addr, addr);
          end
          n_vec++;
          if (snoop_invalidate !== wr) begin
            n_mis++; $display("FAIL snoop_invalidate: got %b want %b", snoop_invalidate, wr);
          end
        end
        snoop_cyc++;
        if (timeout_err) to_cyc = snoop_cyc;
      end
      if (wb_valid) begin
        wbc++;
        if (e_wb) begin
          n_vec++;
          if (wb_addr !== addr || wb_data !== e_d) begin
            n_mis++;
            $display("FAIL wb_stable: got %h/%h want %h/%h", wb_addr, wb_data, addr, e_d);
          end
        end
      end
      if (resp_valid) begin
        done = 1;
        gi = 'x;
        if ($onehot(grant)) for (int i = 0; i < N; i++) if (grant[i]) gi = 2'(i);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_mis++; $display("FAIL resp_unexpected: got state %b", resp_state);
        end else begin
          ex  = exp_q.pop_front();
          got = {gi, resp_state, resp_data_valid, ex[DW] ? resp_data : {DW{1'b0}}};
          if (got !== ex) begin
            n_mis++; $display("FAIL resp: got %h want %h", got, ex);
          end
        end
      end
    end
    n_vec++;
    if (!done) begin
      n_mis++; $display("FAIL resp_wait: got no resp_valid want one within 60 cycles");
    end
    n_vec++;
    if (lat !== 1 + exp_snoop + (e_wb ? stall + 1 : 0)) begin
      n_mis++;
      $display("FAIL latency: got %0d want %0d", lat, 1 + exp_snoop + (e_wb ? stall + 1 : 0));
    end
    n_vec++;
    if (snoop_cyc !== exp_snoop) begin
      n_mis++; $display("FAIL snoop_cycles: got %0d want %0d", snoop_cyc, exp_snoop);
    end
    n_vec++;
    if (wbc !== (e_wb ? stall + 1 : 0)) begin
      n_mis++; $display("FAIL wb_cycles: got %0d want %0d", wbc, e_wb ? stall + 1 : 0);
    end
    n_vec++;
    if (to_cyc !== (e_to ? TO : 0)) begin
      n_mis++; $display("FAIL timeout_cycle: got %0d want %0d", to_cyc, e_to ? TO : 0);
    end
    tick();
    req_valid = '0;
    snoop_ack = '0;
    wb_ready  = 1'b0;
    @(negedge clk);
    n_vec++;
    if (grant !== '0 || dbg_state !== IDLE) begin
      n_mis++; $display("FAIL idle_after_resp: got grant %b state %0d want 0/IDLE", grant, dbg_state);
    end
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '1;
    #3;
    @(negedge clk);
    n_vec++;
    if ({grant, snoop_valid, resp_valid, resp_data_valid, wb_valid, timeout_err} !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got %b want 0",
               {grant, snoop_valid, resp_valid, resp_data_valid, wb_valid, timeout_err});
    end
    n_vec++;
    if (resp_state !== 2'b00) begin
      n_mis++; $display("FAIL reset_resp_state: got %b want 00", resp_state);
    end
    n_vec++;
    if (dbg_state !== IDLE || snoop_target !== '0) begin
      n_mis++; $display("FAIL reset_state: got %0d/%b want IDLE/0", dbg_state, snoop_target);
    end
    req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_all_invalid();
    run_txn(2, 1'b0, 32'h40, 4'b1011, 8'h00, {4{32'h1234_5678}}, 0, 4'b0000);
  endtask

  task automatic test_read_modified_wb();
    run_txn(0, 1'b0, 32'h100, 4'b1110, {2'b11, 2'b00, 2'b01, 2'b00},
            {32'hDEAD_BEEF, 32'h2222_2222, 32'h1111_1111, 32'h0}, 3, 4'b0000);
  endtask

  task automatic test_write_shared();
    run_txn(1, 1'b1, 32'h200, 4'b1101, {2'b01, 2'b00, 2'b00, 2'b01},
            {32'h3333_3333, 32'h2222_2222, 32'h0, 32'hA0A0_0000}, 0, 4'b0000);
  endtask

  task automatic test_write_from_modified();
    run_txn(0, 1'b1, 32'h300, 4'b1110, {2'b11, 2'b10, 2'b00, 2'b00},
            {32'h4444_4444, 32'h5555_5555, 32'h6666_6666, 32'h0}, 2, 4'b0000);
  endtask

  task automatic test_read_lowest_holder();
    run_txn(0, 1'b0, 32'h340, 4'b1110, {2'b10, 2'b01, 2'b01, 2'b00},
            {$urandom, $urandom, $urandom, $urandom}, 0, 4'b0000);
  endtask

  task automatic test_round_robin();
    int ptr, exp_idx, resps, cyc;
    bit prev_resp;
    logic [EW-1:0] ex, got;
    logic [1:0] gi;
    do_reset();
    req_is_write = '0;
    req_valid    = '1;
    ptr = N - 1; resps = 0; cyc = 0; prev_resp = 0;
    while (resps < 5 && cyc < 80) begin
      tick();
      cyc++;
      snoop_ack   = snoop_valid ? snoop_target : '0;
      snoop_state = '0;
      @(negedge clk);
      if (prev_resp) begin
        n_vec++;
        if (grant !== '0) begin
          n_mis++; $display("FAIL rr_idle_gap: got grant %b want 0", grant);
        end
      end
      prev_resp = resp_valid;
      if (snoop_valid) begin
        exp_idx = (ptr + 1) % N;
        n_vec++;
        if (grant !== (N'(1) << exp_idx)) begin
          n_mis++; $display("FAIL rr_order: got %b want %b", grant, N'(1) << exp_idx);
        end
        exp_q.push_back({2'(exp_idx), 2'b10, 1'b0, {DW{1'b0}}});
        ptr = exp_idx;
      end
      if (resp_valid) begin
        resps++;
        gi = 'x;
        if ($onehot(grant)) for (int i = 0; i < N; i++) if (grant[i]) gi = 2'(i);
        n_vec++;
        if (exp_q.size() == 0) begin
          n_mis++; $display("FAIL rr_resp_unexpected: got grant %b", grant);
        end else begin
          ex  = exp_q.pop_front();
          got = {gi, resp_state, resp_data_valid, {DW{1'b0}}};
          if (got !== ex) begin
            n_mis++; $display("FAIL rr_resp: got %h want %h", got, ex);
          end
        end
      end
    end
    n_vec++;
    if (resps < 5) begin
      n_mis++; $display("FAIL rr_wait: got %0d responses want 5", resps);
    end
    tick();
    req_valid = '0;
    snoop_ack = '0;
    @(negedge clk);
  endtask

  task automatic test_snoop_timeout();
    run_txn(1, 1'b0, 32'h480, 4'b0101, {2'b00, 2'b10, 2'b00, 2'b01},
            {32'h0, 32'hEEEE_0002, 32'h0, 32'h5A5A_0000}, 0, 4'b0000);
  endtask

  task automatic test_reset_in_wb();
    bit seen;
    int cyc;
    req_is_write        = '0;
    req_addr[1*AW +: AW] = 32'h80;
    req_valid           = 4'b0010;
    wb_ready            = 1'b0;
    tick();
    snoop_ack   = 4'b1101;
    snoop_state = {2'b00, 2'b11, 2'b00, 2'b00};
    snoop_data  = {32'h0, 32'hCAFE_F00D, 32'h0, 32'h0};
    tick();
    snoop_ack = '0;
    seen = 0; cyc = 0;
    while (!seen && cyc < 5) begin
      @(negedge clk);
      if (wb_valid) seen = 1;
      cyc++;
    end
    n_vec++;
    if (!seen) begin
      n_mis++; $display("FAIL wb_enter: got wb_valid 0 want 1");
    end
    #1 reset = 1'b0;
    #1;
    n_vec++;
    if ({grant, wb_valid, resp_valid, snoop_valid} !== '0 || dbg_state !== IDLE) begin
      n_mis++;
      $display("FAIL async_reset: got %b state %0d want 0/IDLE",
               {grant, wb_valid, resp_valid, snoop_valid}, dbg_state);
    end
    req_valid = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (resp_valid !== 1'b0 || grant !== '0) begin
      n_mis++; $display("FAIL post_reset_quiet: got resp %b grant %b want 0/0", resp_valid, grant);
    end
    // Caches 0 and 3 both request; the reset pointer must favour cache 0.
    run_txn(0, 1'b0, 32'h500, 4'b1110, {2'b01, 2'b01, 2'b00, 2'b00},
            {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h0}, 0, 4'b1000);
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    for (int t = 0; t < 6; t++) begin
      mask = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : '1;
      run_txn($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom, mask,
              8'($urandom), {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 2), 4'b0000);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_read_all_invalid();
    test_read_modified_wb();
    test_write_shared();
    test_write_from_modified();
    test_read_lowest_holder();
    test_round_robin();
    test_snoop_timeout();
    test_reset_in_wb();
    test_random();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL leftover_expected: got %0d entries want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/coherence_bus_arbiter.md
# coherence_bus_arbiter

Parametrised snooping coherence arbiter between NUM_CACHES private L2 caches and the shared L3. Grants one L2 request at a time, round-robin. Broadcasts a snoop to every other L2 and collects their MESI states and data. Returns the resulting MESI state and any cache-to-cache data to the requester, and pushes Modified data back to L3 when a read demotes an M owner.

## Interface
- NUM_CACHES, 4 — number of L2 requesters (≥1)
- ADDR_W, ADDRESS_WIDTH — block address width
- DATA_W, MAIN_MEMORY_DATA_WIDTH — cache line width
- SNOOP_TIMEOUT, 15 — max SNOOP cycles before forced completion (≥1)

Ports:
- clk  in  1  single clock; everything on rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- req_valid  in  NUM_CACHES  per-L2 request; held until its resp_valid
- req_is_write  in  NUM_CACHES  1 = read-for-ownership, 0 = read
- req_addr  in  NUM_CACHES*ADDR_W  per-L2 address, slice i
- grant  out  NUM_CACHES  one-hot owner of the bus
- snoop_valid  out  1  snoop broadcast active
- snoop_addr  out  ADDR_W  registered address of granted request
- snoop_invalidate  out  1  targets must invalidate (write)
- snoop_target  out  NUM_CACHES  ~grant; caches that must ack
- snoop_ack  in  NUM_CACHES  per-L2 snoop acknowledge
- snoop_state  in  NUM_CACHES*MESI_STATE_WIDTH  pre-snoop line state, valid with ack
- snoop_data  in  NUM_CACHES*DATA_W  line data, valid with ack
- resp_valid  out  1  one-cycle completion pulse
- resp_state  out  MESI_STATE_WIDTH  state requester installs
- resp_data_valid  out  1  resp_data came from a peer; 0 = fetch from L3
- resp_data  out  DATA_W  peer line data
- wb_valid / wb_addr / wb_data  out  1 / ADDR_W / DATA_W  writeback to L3
- wb_ready  in  1  L3 accepts writeback
- timeout_err  out  1  one-cycle pulse on snoop timeout

## Operation
- States: IDLE → SNOOP → (WB) → RESP → IDLE.
- IDLE: when any req_valid is set, choose the first set bit searching from rr_ptr+1 with wrap. Register grant, addr and is_write. Clear the ack mask and the counter. Go to SNOOP.
- SNOOP:
  - snoop_valid=1.
  - On each cycle, a snoop_ack[i] with snoop_target[i]=1 sets mask bit i and captures state[i] and data[i]. Acks from non-targets and repeated acks are ignored.
  - Complete when mask == snoop_target, or when the counter reaches SNOOP_TIMEOUT. On timeout, pulse timeout_err and treat missing caches as I.
  - NUM_CACHES=1: target is empty, so SNOOP completes in its first cycle.
- Resolution (lowest index wins among equal candidates):
  - Read, any M: resp_state=S, data from the M holder, resp_data_valid=1, go to WB.
  - Read, any E/S: resp_state=S, data from the lowest E/S holder, go to RESP.
  - Read, all I: resp_state=E, resp_data_valid=0.
  - Write: resp_state=M. Data comes from an M holder, else E/S, else resp_data_valid=0. No writeback, because dirty ownership transfers.
- WB: wb_valid=1 with address and data held stable until a wb_ready cycle, then go to RESP.
- RESP: resp_valid=1 for one cycle, rr_ptr ← granted index, grant cleared on entry to IDLE.
- Dropping req_valid mid-transaction does not abort; the transaction completes.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=NUM_CACHES-1 (cache 0 wins first).
  - All outputs 0; resp_state=I (2'b00).
- Reset mid-transaction: immediate return to IDLE, all outputs 0, no response issued.
- Latency:
  - Request seen at edge t0.
  - grant and snoop_valid high after t0.
  - Acks sampled at t1 → RESP after t1, resp_valid high for the cycle t1–t2.
  - Minimum request-to-resp_valid latency is 2 cycles.
  - WB adds 1 cycle plus the wb_ready stall.
- grant stays high from the SNOOP entry cycle through the RESP cycle inclusive.
- A new grant is earliest 1 cycle after RESP (through IDLE).
- Timeout: SNOOP lasts at most SNOOP_TIMEOUT cycles. timeout_err is coincident with the last SNOOP cycle.
- An ack arriving in the same cycle the timeout fires still counts.

## Structure
- cache_config package holds:
  - mesi_state_t with I=2'b00, S=2'b01, E=2'b10, M=2'b11 (MESI_STATE_WIDTH=2).
  - arb_state_t {IDLE, SNOOP, WB, RESP}.
- Sub-module rr_priority_picker #(N): inputs req and ptr; outputs one-hot grant and index. Combinational, reused by future arbiters.

## Test plan
- NUM_CACHES=4, cache 2 read at 0x40, all acks I in the first SNOOP cycle → resp_valid 2 cycles after the request, resp_state=E, resp_data_valid=0, no wb_valid.
- Cache 0 read, cache 3 acks M with data 0xDEADBEEF, wb_ready low for 3 cycles → wb_valid held for 4 cycles with wb_addr/wb_data stable; then resp_state=S, resp_data=0xDEADBEEF.
- Cache 1 write, caches 0/3 ack S, cache 2 acks I → snoop_invalidate=1, resp_state=M, resp_data from cache 0.
- All four req_valid held continuously → grant order 0,1,2,3,0; no cache granted twice before the others.
- Cache 3 never acks, SNOOP_TIMEOUT=15 → timeout_err pulses on SNOOP cycle 15 and the response is formed from the remaining acks.
- Reset driven low during WB → grant, wb_valid and resp_valid are 0 immediately; after reset release, the next request goes to cache 0 first.
